memristor_bank: RTL and testbench

- Clocked, synthesisable, fixed-point successor to the single-device behavioural memristor model.
- Holds N_CELLS independent memristor states, each a doped-width fraction.
- Serves READ, multi-pulse PROGRAM and RESET_STATE commands through a valid/ready command port and a valid/ready response port.
- Sits between the crossbar controller and the column sense logic as the device-state store for one crossbar row.

---
 rtl/memxbar_pkg.sv | 29 ++
 rtl/memristor_conductance.sv | 34 +++
 rtl/memristor_bank.sv | 134 +++++++++++++
 tb/tb_memristor_bank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/memxbar_pkg.sv
// memxbar_pkg: shared types and helpers for the memristor crossbar blocks
//   cmd_op_e     - command opcodes on the bank command port
//   bank_state_e - bank control FSM states
//   sat_add      - unsigned state plus signed step, clamped to [0, max_v]
package memxbar_pkg;

    typedef enum logic [1:0] {
        OP_READ,
        OP_PROGRAM,
        OP_RESET_STATE,
        OP_ILLEGAL
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } bank_state_e;

    // s is an unsigned state, d a two's-complement step; two guard bits keep
    // the sum exact before clamping
    function automatic logic [31:0] sat_add(input logic [31:0] s, input logic [31:0] d,
                                            input logic [31:0] max_v);
        logic signed [33:0] sum;
        sum = $signed({2'b00, s}) + $signed({{2{d[31]}}, d});
        return (sum < 0) ? 32'd0 : (sum > $signed({2'b00, max_v})) ? max_v : sum[31:0];
    endfunction

endpackage

// File: rtl/memristor_conductance.sv
// memristor_conductance: doped-width state to conductance, then voltage * G
//   state_i   - unsigned doped-width fraction (0 = R_off, all ones = R_on)
//   voltage_i - signed applied voltage
//   current_o - signed full-precision voltage * G
module memristor_conductance #(
    parameter int W_BITS = 16,
    parameter int V_BITS = 8,
    parameter int G_BITS = 16,
    parameter int G_ON   = 10000,
    parameter int G_OFF  = 63
) (
    input  logic [W_BITS-1:0]              state_i,
    input  logic [V_BITS-1:0]              voltage_i,
    output logic signed [V_BITS+G_BITS:0]  current_o
);

    localparam int CW = V_BITS + G_BITS + 1;
    localparam logic [31:0] G_SPAN = 32'(G_ON - G_OFF);

    logic [31:0]          prod;
    logic [G_BITS-1:0]    g;
    logic signed [CW-1:0] v_ext;
    logic signed [CW-1:0] g_ext;

    // G is unsigned, so it gets a zero sign bit before the signed multiply
    always_comb begin
        prod      = G_SPAN * 32'(state_i);
        g         = G_BITS'(32'(G_OFF) + (prod >> W_BITS));
        v_ext     = {{(CW-V_BITS){voltage_i[V_BITS-1]}}, voltage_i};
        g_ext     = {{(CW-G_BITS){1'b0}}, g};
        current_o = v_ext * g_ext;
    end

endmodule

// File: rtl/memristor_bank.sv
// memristor_bank: N_CELLS memristor device states served over valid/ready ports
//   cmd_valid/cmd_ready - command handshake; cmd_op, cmd_addr, cmd_voltage, cmd_pulses
//   rsp_valid/rsp_ready - response handshake; rsp_current, rsp_state, rsp_err
//   busy                - high whenever a command is in flight
module memristor_bank
    import memxbar_pkg::*;
#(
    parameter int N_CELLS = 8,
    parameter int W_BITS  = 16,
    parameter int V_BITS  = 8,
    parameter int G_BITS  = 16,
    parameter int G_ON    = 10000,
    parameter int G_OFF   = 63,
    parameter int MU_GAIN = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(N_CELLS)-1:0]   cmd_addr,
    input  logic [V_BITS-1:0]            cmd_voltage,
    input  logic [7:0]                   cmd_pulses,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic signed [V_BITS+G_BITS:0] rsp_current,
    output logic [W_BITS-1:0]            rsp_state,
    output logic                         rsp_err,
    output logic                         busy
);

    localparam int AW = $clog2(N_CELLS);
    localparam int CW = V_BITS + G_BITS + 1;
    localparam logic [W_BITS-1:0] HALF  = {1'b1, {(W_BITS-1){1'b0}}};
    localparam logic [31:0]       MAX_S = {{(32-W_BITS){1'b0}}, {W_BITS{1'b1}}};

    bank_state_e          state_q, state_d;
    cmd_op_e              op_q, op_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [V_BITS-1:0]    volt_q, volt_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [W_BITS-1:0]    cells_q [N_CELLS];
    logic signed [CW-1:0] rsp_current_q, rsp_current_d;
    logic [W_BITS-1:0]    rsp_state_q, rsp_state_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [W_BITS-1:0]    cur;
    logic [W_BITS-1:0]    cell_d;
    logic [31:0]          step;
    logic signed [CW-1:0] cur_i;
    logic                 err, prog, last, cell_we;

    // conductance and current always follow the post-update cell value
    memristor_conductance #(
        .W_BITS (W_BITS),
        .V_BITS (V_BITS),
        .G_BITS (G_BITS),
        .G_ON   (G_ON),
        .G_OFF  (G_OFF)
    ) u_cond (
        .state_i   (cell_d),
        .voltage_i (volt_q),
        .current_o (cur_i)
    );

    always_comb begin
        err     = (op_q == OP_ILLEGAL) || (32'(addr_q) >= 32'(N_CELLS));
        cur     = cells_q[addr_q];
        step    = {{(32-V_BITS){volt_q[V_BITS-1]}}, volt_q} << MU_GAIN;
        prog    = (op_q == OP_PROGRAM) && (cnt_q != 8'd0);
        cell_d  = prog ? W_BITS'(sat_add(32'(cur), step, MAX_S))
                       : (op_q == OP_RESET_STATE) ? HALF : cur;
        cell_we = (state_q == EXEC) && !err && (prog || op_q == OP_RESET_STATE);
        // errors, READ, RESET_STATE and zero-pulse PROGRAM all take one EXEC cycle
        last    = err || !(prog && cnt_q > 8'd1);
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        volt_d        = volt_q;
        cnt_d         = cnt_q;
        rsp_current_d = rsp_current_q;
        rsp_state_d   = rsp_state_q;
        rsp_err_d     = rsp_err_q;
        if (state_q == IDLE && cmd_valid) begin
            state_d = EXEC;
            op_d    = cmd_op_e'(cmd_op);
            addr_d  = cmd_addr;
            volt_d  = cmd_voltage;
            cnt_d   = cmd_pulses;
        end
        if (state_q == EXEC) begin
            cnt_d = prog ? cnt_q - 8'd1 : cnt_q;
            if (last) begin
                state_d       = RESP;
                rsp_state_d   = err ? '0 : cell_d;
                rsp_current_d = (err || op_q == OP_RESET_STATE) ? '0 : cur_i;
                rsp_err_d     = err;
            end
        end
        if (state_q == RESP && rsp_ready) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= OP_READ;
            addr_q        <= '0;
            volt_q        <= '0;
            cnt_q         <= '0;
            rsp_current_q <= '0;
            rsp_state_q   <= '0;
            rsp_err_q     <= 1'b0;
            for (int i = 0; i < N_CELLS; i++) cells_q[i] <= HALF;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            volt_q        <= volt_d;
            cnt_q         <= cnt_d;
            rsp_current_q <= rsp_current_d;
            rsp_state_q   <= rsp_state_d;
            rsp_err_q     <= rsp_err_d;
            if (cell_we) cells_q[addr_q] <= cell_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = !cmd_ready;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_current = rsp_current_q;
    assign rsp_state   = rsp_state_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_memristor_bank.sv
// tb_memristor_bank: randomized and directed checks of memristor_bank against a behavioural model
//   Six cells are instantiated so that out-of-range addresses (6, 7) fit the address port.
module tb_memristor_bank;

    localparam int NC = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic [2:0]         cmd_addr = 3'd0;
    logic [7:0]         cmd_voltage = 8'd0;
    logic [7:0]         cmd_pulses = 8'd0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic signed [24:0] rsp_current;
    logic [15:0]        rsp_state;
    logic               rsp_err;
    logic               busy;

    int     n_chk = 0;
    int     n_pass = 0;
    longint mdl [NC];

    always #5 clk = ~clk;

    memristor_bank #(.N_CELLS(NC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_voltage (cmd_voltage),
        .cmd_pulses  (cmd_pulses),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_current (rsp_current),
        .rsp_state   (rsp_state),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // conductance from the device rule, on a plain integer state
    function automatic longint g_of(input longint s);
        return 63 + ((10000 - 63) * s) / 65536;
    endfunction

    // issue one command at a negedge and check latency and response against the model
    task automatic run_cmd(input int op, input int addr, input int v, input int p, input bit hold);
        longint s, es, ec, el;
        bit     e;
        int     n;
        e = (op == 3) || (addr >= NC);
        s = e ? 0 : mdl[addr];
        if (!e && op == 1)
            for (int k = 0; k < p; k++) begin
                s = s + v * 64;
                s = (s < 0) ? 0 : (s > 65535) ? 65535 : s;
            end
        if (!e && op == 2) s = 32768;
        if (!e) mdl[addr] = s;
        es = e ? 0 : s;
        ec = (e || op == 2) ? 0 : v * g_of(s);
        el = (op == 1 && !e && p > 0) ? p + 1 : 2;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_op      = 2'(op);
        cmd_addr    = 3'(addr);
        cmd_voltage = 8'(v);
        cmd_pulses  = 8'(p);
        cmd_valid   = 1'b1;
        rsp_ready   = !hold;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        check("latency", n, el);
        check("rsp_state", rsp_state, es);
        check("rsp_current", rsp_current, ec);
        check("rsp_err", rsp_err, e);
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                cmd_valid = (k == 3);
                cmd_op    = 2'd2;
                check("bp_valid", rsp_valid, 1);
                check("bp_cmd_ready", cmd_ready, 0);
                check("bp_state", rsp_state, es);
                check("bp_current", rsp_current, ec);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("ready_after_hs", cmd_ready, 1);
        check("valid_after_hs", rsp_valid, 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        for (int i = 0; i < NC; i++) mdl[i] = 32768;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_state", rsp_state, 0);
        check("rst_rsp_current", rsp_current, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);

        run_cmd(0, 3, 10, 0, 0);
        run_cmd(1, 1, 64, 4, 0);
        run_cmd(0, 0, 0, 0, 0);
        run_cmd(1, 2, 127, 255, 0);
        run_cmd(1, 2, -128, 255, 0);
        run_cmd(0, 1, 5, 0, 1);
        run_cmd(0, 1, -7, 0, 0);
        run_cmd(3, 4, 20, 3, 0);
        run_cmd(1, 7, 50, 10, 0);
        run_cmd(0, 6, 9, 0, 0);
        run_cmd(1, 5, 30, 0, 0);
        run_cmd(2, 1, 40, 0, 0);
        run_cmd(0, 1, 40, 0, 0);

        for (int t = 0; t < 40; t++)
            run_cmd($urandom_range(3), $urandom_range(7), $signed($urandom_range(255)) - 128,
                    $urandom_range(20), ($urandom_range(3) == 0));

        // asynchronous reset in the middle of a long PROGRAM
        run_cmd(0, 4, 1, 0, 0);
        cmd_op = 2'd1; cmd_addr = 3'd4; cmd_voltage = 8'd50; cmd_pulses = 8'd200;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (49) @(posedge clk);
        #2;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        for (int i = 0; i < NC; i++) mdl[i] = 32768;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        check("no_stale_rsp", stray, 0);
        for (int i = 0; i < NC; i++) run_cmd(0, i, 3, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
